hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Load-use / control hazard unit for an in-order pipeline whose loads take
// LOAD_LAT cycles after EX before their data can be forwarded, and whose taken
// jumps squash FLUSH_DEPTH consecutive IF/ID slots.
//
// Parameters
//   LOAD_LAT    (1..4) cycles after EX before load data is forwardable
//   FLUSH_DEPTH (1..3) consecutive Flush cycles per accepted jump
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   IDEX_MemRead      instruction in EX is a load
//   IDEX_RegisterRd   destination register of the EX instruction
//   IFID_Register1/2  rs1 / rs2 of the ID instruction
//   B, Jalr           ID instruction is a branch / JALR (operands needed in ID)
//   Jump              control transfer decided in ID this cycle
//   PCWrite           PC update enable            (combinational)
//   IFIDWrite         IF/ID write enable          (combinational)
//   Bolha             insert bubble into ID/EX    (combinational)
//   Flush             squash IF/ID contents       (combinational)
//   stall_cycles      saturating count of stall cycles  (HAZARD_STATS_EN only)
//   flush_cycles      saturating count of flush cycles  (HAZARD_STATS_EN only)
//
// Configuration macro: HAZARD_STATS_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_RegisterRd,
    input  logic [4:0]  IFID_Register1,
    input  logic [4:0]  IFID_Register2,
    input  logic        B,
    input  logic        Jalr,
    input  logic        Jump,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
`endif
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        Bolha,
    output logic        Flush
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned FCNT_W = 2;

    // Loads that have left EX; index k means k+1 cycles past EX.
    logic [LOAD_LAT-1:0]            q_valid;
    logic [LOAD_LAT-1:0][REG_W-1:0] q_rd;
    logic [FCNT_W-1:0]              fcnt;

    logic hz_general;
    logic hz_branch;
    logic squash;
    logic stall;
    logic jump_accept;

    // Nonzero register that the ID instruction reads.
    function automatic logic reg_match(input logic [REG_W-1:0] x,
                                       input logic [REG_W-1:0] rs1,
                                       input logic [REG_W-1:0] rs2);
        return (x != '0) && ((x == rs1) || (x == rs2));
    endfunction

    // Hazard detection: ALU consumers can take forwarded data once the load
    // reaches the last queue slot; ID-resolved consumers need one cycle more.
    always_comb begin
        hz_general = IDEX_MemRead &&
                     reg_match(IDEX_RegisterRd, IFID_Register1, IFID_Register2);
        hz_branch  = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (q_valid[k] && reg_match(q_rd[k], IFID_Register1, IFID_Register2)) begin
                hz_branch = 1'b1;
                if (k < int'(LOAD_LAT) - 1) begin
                    hz_general = 1'b1;
                end
            end
        end
        hz_branch = hz_branch && (B || Jalr);
    end

    // Stall/flush decision; squash cycles mask the ID instruction entirely.
    always_comb begin
        squash      = (fcnt != '0);
        stall       = rst_n && !squash && (hz_general || hz_branch);
        jump_accept = rst_n && !squash && !stall && Jump;
        PCWrite     = !stall;
        IFIDWrite   = !stall;
        Bolha       = stall;
        Flush       = rst_n && (squash || jump_accept);
    end

    // Load queue shifts every cycle regardless of ID stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= '0;
            q_rd    <= '0;
        end else begin
            q_valid[0] <= IDEX_MemRead && (IDEX_RegisterRd != '0);
            q_rd[0]    <= IDEX_RegisterRd;
            for (int k = 1; k < int'(LOAD_LAT); k++) begin
                q_valid[k] <= q_valid[k-1];
                q_rd[k]    <= q_rd[k-1];
            end
        end
    end

    // Remaining flush cycles after the current one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (jump_accept) begin
            fcnt <= FCNT_W'(FLUSH_DEPTH - 1);
        end else if (squash) begin
            fcnt <= fcnt - FCNT_W'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (Flush && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
